regfile_io_ctl: RTL and testbench



---
 rtl/regfile_io_pkg.sv | 25 ++
 rtl/regfile_io_ctl_sync.sv | 29 ++
 rtl/regfile_io_ctl.sv | 160 ++++++++++++++++
 tb/tb_regfile_io_ctl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/regfile_io_pkg.sv
// Shared types and helpers for the register/IO file.
//   state_e     : controller state (INIT sweep, RUN)
//   addr_cls_e  : storage class of an address (output port, input port, general)
//   INIT_ZERO / INIT_INDEX : values of the INIT_MODE parameter
//   addr_class(): classifies an address given the output/input port counts
package regfile_io_pkg;

  typedef enum logic {INIT, RUN} state_e;

  typedef enum logic [1:0] {CLS_OUT, CLS_IN, CLS_GEN} addr_cls_e;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;

  // Output ports sit at the bottom of the map, input ports directly above,
  // everything else is general storage.
  function automatic addr_cls_e addr_class(input int unsigned addr,
                                           input int unsigned n_out,
                                           input int unsigned n_in);
    if (addr < n_out)        return CLS_OUT;
    if (addr < n_out + n_in) return CLS_IN;
    return CLS_GEN;
  endfunction

endpackage

// File: rtl/regfile_io_ctl_sync.sv
// Two-flop synchroniser for one input-port slice, falling-edge clocked.
//   nclk : clock (state on falling edge)
//   nrst : async active-low reset, clears both stages
//   d_i  : asynchronous pin data
//   q_o  : synchronised data, two falling edges behind d_i
module io_sync2 #(
  parameter int DATA_W = 8
) (
  input  logic              nclk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q_o
);

  logic [DATA_W-1:0] s1_q, s2_q;

  always_ff @(negedge nclk or negedge nrst) begin
    if (!nrst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/regfile_io_ctl.sv
// Parametrised register file with memory-mapped I/O ports.
//   nclk                 : clock, all state updates on the falling edge
//   nrst                 : async active-low reset
//   enable/address_D/data_in : write port
//   address_A/address_B  : combinational read ports -> out_A/out_B
//   port_in              : external inputs, slice k read at address N_OUT+k
//   port_out             : slice k is output register k
//   busy                 : high while the general registers are being swept
//   wr_err               : one-cycle pulse when a write targets an input port
// After reset the general registers (above the port registers) are filled
// with zero or their own index, one per edge, before normal operation.
module regfile_io_ctl
  import regfile_io_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int N_OUT     = 1,
  parameter int N_IN      = 1,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 0
) (
  input  logic                    nclk,
  input  logic                    nrst,
  input  logic                    enable,
  input  logic [ADDR_W-1:0]       address_A,
  input  logic [ADDR_W-1:0]       address_B,
  input  logic [ADDR_W-1:0]       address_D,
  input  logic [DATA_W-1:0]       data_in,
  input  logic [N_IN*DATA_W-1:0]  port_in,
  output logic [DATA_W-1:0]       out_A,
  output logic [DATA_W-1:0]       out_B,
  output logic [N_OUT*DATA_W-1:0] port_out,
  output logic                    busy,
  output logic                    wr_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int BASE  = N_OUT + N_IN;
  localparam int NGEN  = DEPTH - BASE;
  localparam int MEM_N = (NGEN > 0) ? NGEN : 1;

  if (N_OUT < 1 || N_IN < 1 || BASE > DEPTH) begin : g_bad_cfg
    $error("regfile_io_ctl: need N_OUT>=1, N_IN>=1, N_OUT+N_IN<=2**ADDR_W");
  end
  if (INIT_MODE != INIT_ZERO && INIT_MODE != INIT_INDEX) begin : g_bad_init
    $error("regfile_io_ctl: INIT_MODE must be 0 or 1");
  end

  state_e                         state_q;
  logic [ADDR_W-1:0]              idx_q;
  logic                           busy_q, wr_err_q;
  logic [N_OUT-1:0][DATA_W-1:0]   out_q;
  logic [N_IN-1:0][DATA_W-1:0]    in_sync;
  logic [DATA_W-1:0]              gen_mem [MEM_N];

  // ---------------------------------------------------------------- inputs
  for (genvar k = 0; k < N_IN; k++) begin : g_in
    io_sync2 #(.DATA_W(DATA_W)) u_sync (
      .nclk (nclk),
      .nrst (nrst),
      .d_i  (port_in[k*DATA_W +: DATA_W]),
      .q_o  (in_sync[k])
    );
  end

  // --------------------------------------------------------- write decode
  addr_cls_e          cls_d;
  logic               wr_run;
  logic               gen_we;
  logic [ADDR_W-1:0]  gen_waddr;
  logic [DATA_W-1:0]  gen_wdata;
  logic [DATA_W-1:0]  init_val;

  assign cls_d    = addr_class(32'(address_D), N_OUT, N_IN);
  // A write that will actually land this edge (input ports are read-only).
  assign wr_run   = (state_q == RUN) && enable && (cls_d != CLS_IN);
  assign init_val = (INIT_MODE == INIT_INDEX) ? DATA_W'(idx_q) : '0;

  always_comb begin
    gen_we    = 1'b0;
    gen_waddr = address_D;
    gen_wdata = data_in;
    if (state_q == INIT) begin
      gen_we    = 1'b1;
      gen_waddr = idx_q;
      gen_wdata = init_val;
    end else if (wr_run && cls_d == CLS_GEN) begin
      gen_we    = 1'b1;
    end
  end

  // General storage has no reset; the sweep is what clears it.
  always_ff @(negedge nclk) begin
    for (int k = 0; k < NGEN; k++) begin
      if (gen_we && gen_waddr == ADDR_W'(BASE + k)) gen_mem[k] <= gen_wdata;
    end
  end

  // ------------------------------------------------------ controller + ports
  always_ff @(negedge nclk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= INIT;
      idx_q    <= ADDR_W'(BASE);
      busy_q   <= 1'b1;
      wr_err_q <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_err_q <= 1'b0;
      case (state_q)
        INIT: begin
          if (NGEN == 0 || idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        RUN: begin
          if (enable) begin
            if (cls_d == CLS_IN) wr_err_q <= 1'b1;
            for (int k = 0; k < N_OUT; k++) begin
              if (cls_d == CLS_OUT && address_D == ADDR_W'(k)) out_q[k] <= data_in;
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // ----------------------------------------------------------------- reads
  // General registers read as zero until the sweep has finished.
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_OUT; k++)
      if (a == ADDR_W'(k)) v = out_q[k];
    for (int k = 0; k < N_IN; k++)
      if (a == ADDR_W'(N_OUT + k)) v = in_sync[k];
    if (state_q == RUN) begin
      for (int k = 0; k < NGEN; k++)
        if (a == ADDR_W'(BASE + k)) v = gen_mem[k];
    end
    return v;
  endfunction

  always_comb begin
    out_A = rd(address_A);
    out_B = rd(address_B);
    if (BYPASS != 0 && wr_run) begin
      if (address_D == address_A) out_A = data_in;
      if (address_D == address_B) out_B = data_in;
    end
  end

  assign port_out = out_q;
  assign busy     = busy_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_regfile_io_ctl.sv
module tb_regfile_io_ctl;

  logic       nclk = 1'b1;
  logic       nrst;
  logic       enable;
  logic [3:0] aA, aB, aD;
  logic [7:0] din, pin;
  logic [7:0] oA0, oB0, po0, oA1, oB1, po1;
  logic       busy0, err0, busy1, err1;

  int checks = 0;
  int failures = 0;

  always #5 nclk = ~nclk;

  // dut0: defaults (zero init, bypass). dut1: index init, no bypass.
  regfile_io_ctl #(.INIT_MODE(0), .BYPASS(1)) dut0 (
    .nclk(nclk), .nrst(nrst), .enable(enable), .address_A(aA), .address_B(aB),
    .address_D(aD), .data_in(din), .port_in(pin), .out_A(oA0), .out_B(oB0),
    .port_out(po0), .busy(busy0), .wr_err(err0));

  regfile_io_ctl #(.INIT_MODE(1), .BYPASS(0)) dut1 (
    .nclk(nclk), .nrst(nrst), .enable(enable), .address_A(aA), .address_B(aB),
    .address_D(aD), .data_in(din), .port_in(pin), .out_A(oA1), .out_B(oB1),
    .port_out(po1), .busy(busy1), .wr_err(err1));

  typedef struct {
    logic       en;
    logic [3:0] a, b, d;
    logic [7:0] din;
    logic [7:0] ea0, eb0, ea1, eb1;
    logic       eerr;
    logic [7:0] epo;
  } vec_t;

  vec_t vt[8];
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d, input logic [7:0] v);
    enable = en; aA = a; aB = b; aD = d; din = v;
  endtask

  // Counts negedges until dut0 busy drops, bounded.
  task automatic wait_sweep(output int n, output logic err_seen);
    n = 0;
    err_seen = 1'b0;
    while (busy0 && n < 40) begin
      @(negedge nclk); #1;
      n++;
      err_seen = err_seen | err0 | err1;
      if (n == 5) enable = 1'b0;
    end
  endtask

  int   n;
  logic es;
  vec_t e;

  initial begin
    nrst = 1'b0; pin = 8'h00;
    drive(1'b0, 4'd0, 4'd0, 4'd0, 8'h00);

    vt[0] = '{1'b0, 4'd7,  4'd15, 4'd0,  8'h00, 8'h00, 8'h00, 8'h07, 8'h0F, 1'b0, 8'h00};
    vt[1] = '{1'b0, 4'd12, 4'd9,  4'd0,  8'h00, 8'h00, 8'h00, 8'h0C, 8'h09, 1'b0, 8'h00};
    vt[2] = '{1'b1, 4'd0,  4'd0,  4'd0,  8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 1'b0, 8'hA5};
    vt[3] = '{1'b0, 4'd0,  4'd12, 4'd0,  8'h00, 8'hA5, 8'h00, 8'hA5, 8'h0C, 1'b0, 8'hA5};
    vt[4] = '{1'b1, 4'd12, 4'd3,  4'd12, 8'h5A, 8'h5A, 8'h00, 8'h0C, 8'h03, 1'b0, 8'hA5};
    vt[5] = '{1'b0, 4'd12, 4'd12, 4'd0,  8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1'b0, 8'hA5};
    vt[6] = '{1'b1, 4'd15, 4'd14, 4'd15, 8'h33, 8'h33, 8'h00, 8'h0F, 8'h0E, 1'b0, 8'hA5};
    vt[7] = '{1'b0, 4'd15, 4'd0,  4'd0,  8'h00, 8'h33, 8'hA5, 8'h33, 8'hA5, 1'b0, 8'hA5};

    // Reset for 3 cycles.
    repeat (3) @(posedge nclk);
    #1;
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_port_out", 32'(po0), 32'h00);
    chk("rst_wr_err", 32'(err0), 32'd0);

    // Release, and attempt a write to reg 12 during the sweep.
    nrst = 1'b1;
    drive(1'b1, 4'd9, 4'd1, 4'd12, 8'h55);
    #2;
    chk("init_read_gen", 32'(oA0), 32'h00);
    chk("init_read_in", 32'(oB0), 32'h00);
    wait_sweep(n, es);
    chk("sweep_len", 32'(n), 32'd14);
    chk("sweep_no_err", 32'(es), 32'd0);
    chk("busy1_low", 32'(busy1), 32'd0);
    chk("post_sweep_port_out", 32'(po0), 32'h00);

    // Table vectors through the scoreboard.
    for (int i = 0; i < 8; i++) begin
      @(posedge nclk); #1;
      drive(vt[i].en, vt[i].a, vt[i].b, vt[i].d, vt[i].din);
      sb.push_back(vt[i]);
      #2;
      e = sb[0];
      chk($sformatf("v%0d_A0", i), 32'(oA0), 32'(e.ea0));
      chk($sformatf("v%0d_B0", i), 32'(oB0), 32'(e.eb0));
      chk($sformatf("v%0d_A1", i), 32'(oA1), 32'(e.ea1));
      chk($sformatf("v%0d_B1", i), 32'(oB1), 32'(e.eb1));
      @(negedge nclk); #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_err", i), 32'(err0), 32'(e.eerr));
      chk($sformatf("v%0d_po0", i), 32'(po0), 32'(e.epo));
      chk($sformatf("v%0d_po1", i), 32'(po1), 32'(e.epo));
    end

    // Input synchroniser latency and write protection.
    @(posedge nclk); #1;
    drive(1'b0, 4'd1, 4'd1, 4'd0, 8'h00);
    pin = 8'h3C;
    #2;
    chk("sync_pre", 32'(oA0), 32'h00);
    @(negedge nclk); #1;
    chk("sync_edge1", 32'(oA0), 32'h00);
    @(negedge nclk); #1;
    chk("sync_edge2", 32'(oA0), 32'h3C);
    chk("sync_edge2_dut1", 32'(oB1), 32'h3C);
    @(posedge nclk); #1;
    drive(1'b1, 4'd1, 4'd1, 4'd1, 8'hFF);
    #2;
    chk("inwr_no_bypass", 32'(oA0), 32'h3C);
    @(negedge nclk); #1;
    chk("inwr_err", 32'(err0), 32'd1);
    chk("inwr_err1", 32'(err1), 32'd1);
    enable = 1'b0;
    @(negedge nclk); #1;
    chk("inwr_err_pulse", 32'(err0), 32'd0);
    chk("inwr_reg_kept", 32'(oA0), 32'h3C);

    // Reset during a sweep: run to sweep index 8, then reset again.
    @(posedge nclk); #1;
    nrst = 1'b0;
    #1;
    chk("rst2_port_out", 32'(po0), 32'h00);
    @(posedge nclk); #1;
    nrst = 1'b1;
    drive(1'b0, 4'd7, 4'd15, 4'd0, 8'h00);
    repeat (6) @(negedge nclk);
    #1;
    chk("mid_sweep_busy", 32'(busy0), 32'd1);
    @(posedge nclk); #1;
    nrst = 1'b0;
    #1;
    chk("rst3_busy", 32'(busy0), 32'd1);
    @(posedge nclk); #1;
    nrst = 1'b1;
    wait_sweep(n, es);
    chk("resweep_len", 32'(n), 32'd14);
    chk("resweep_A1", 32'(oA1), 32'h07);
    chk("resweep_B1", 32'(oB1), 32'h0F);
    aA = 4'd12;
    #1;
    chk("resweep_reg12_dut0", 32'(oA0), 32'h00);
    chk("resweep_reg12_dut1", 32'(oA1), 32'h0C);
    chk("resweep_port_out", 32'(po0), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
